// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl - run/stop/lap sequencer for the tenth-second stopwatch.
// Turns the raw start/stop and lap/reset buttons into one-cycle presses.
// Runs the four-state control FSM and the 0.1 s prescaler.
// Drives the registered tick / clr / hold / state outputs to the datapath.
// Optional feature: define STOPWATCH_CTRL_DEBOUNCE_EN to insert a
// DEBOUNCE_CYCLES stable-level debouncer behind each button synchronizer.
// Without it the debounced level is the synchronizer output.
module stopwatch_ctrl #(
  parameter int CLK_FREQ_HZ     = 50000000,
  parameter int TICK_HZ         = 10,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lr,
  input  logic       cnt_max,
  output logic       tick,
  output logic       clr,
  output logic       hold,
  output logic [1:0] state
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_LAP  = 2'b10,
    S_STOP = 2'b11
  } state_t;

  // Bit 0 carries the start/stop button, bit 1 the lap/reset button.
  logic [1:0]    sync1_r;
  logic [1:0]    sync2_r;
  logic [1:0]    db_s;
  logic [1:0]    prev_r;
  logic [1:0]    press_s;
  logic          ss_s;
  logic          lr_s;

  state_t        state_r;
  state_t        state_nx_s;
  logic [PW-1:0] pre_r;
  logic [PW-1:0] pre_nx_s;
  logic          tick_r;
  logic          tick_nx_s;
  logic          clr_r;
  logic          clr_nx_s;
  logic          hold_r;
  logic          active_s;
  logic          wrap_s;

  // Two-flop synchronizer bringing both raw buttons into the clk domain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
    end else begin
      sync1_r <= {btn_lr, btn_ss};
      sync2_r <= sync1_r;
    end
  end

`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_ONE  = DW'(1);

  logic [1:0]    db_r;
  logic [DW-1:0] db_cnt_r [2];

  // Debouncer: adopt the synchronized level only after it has differed for
  // DEBOUNCE_CYCLES consecutive cycles; any agreeing sample restarts the count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_r        <= 2'b00;
      db_cnt_r[0] <= {DW{1'b0}};
      db_cnt_r[1] <= {DW{1'b0}};
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] == db_r[i]) begin
          db_cnt_r[i] <= {DW{1'b0}};
        end else if (db_cnt_r[i] == DB_LAST) begin
          db_r[i]     <= sync2_r[i];
          db_cnt_r[i] <= {DW{1'b0}};
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
        end
      end
    end
  end

  assign db_s = db_r;
`else
  assign db_s = sync2_r;
`endif

  // Edge-detector history: a press is the debounced level rising
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_r <= 2'b00;
    end else begin
      prev_r <= db_s;
    end
  end

  assign press_s  = db_s & ~prev_r;
  assign ss_s     = press_s[0];
  assign lr_s     = press_s[1];
  assign active_s = (state_r == S_RUN) || (state_r == S_LAP);
  assign wrap_s   = active_s && (pre_r == PRE_LAST);

  // Next-state, prescaler and pulse decode; overflow beats any press, ss beats lr
  always_comb begin
    state_nx_s = state_r;
    pre_nx_s   = pre_r;
    tick_nx_s  = 1'b0;
    clr_nx_s   = 1'b0;

    if (active_s) begin
      if (wrap_s) begin
        pre_nx_s = {PW{1'b0}};
      end else begin
        pre_nx_s = pre_r + PRE_ONE;
      end
    end else if (state_r == S_IDLE) begin
      pre_nx_s = {PW{1'b0}};
    end else begin
      pre_nx_s = pre_r;
    end

    if (wrap_s && cnt_max) begin
      state_nx_s = S_STOP;
    end else begin
      tick_nx_s = wrap_s;
      case (state_r)
        S_IDLE: begin
          if (ss_s) begin
            state_nx_s = S_RUN;
          end else if (lr_s) begin
            state_nx_s = S_IDLE;
            clr_nx_s   = 1'b1;
          end else begin
            state_nx_s = S_IDLE;
          end
        end
        S_RUN: begin
          if (ss_s) begin
            state_nx_s = S_STOP;
          end else if (lr_s) begin
            state_nx_s = S_LAP;
          end else begin
            state_nx_s = S_RUN;
          end
        end
        S_LAP: begin
          if (ss_s) begin
            state_nx_s = S_STOP;
          end else if (lr_s) begin
            state_nx_s = S_RUN;
          end else begin
            state_nx_s = S_LAP;
          end
        end
        S_STOP: begin
          if (ss_s) begin
            state_nx_s = S_RUN;
          end else if (lr_s) begin
            state_nx_s = S_IDLE;
            clr_nx_s   = 1'b1;
          end else begin
            state_nx_s = S_STOP;
          end
        end
        default: begin
          state_nx_s = S_IDLE;
        end
      endcase
    end
  end

  // State, prescaler and output registers; hold is decoded from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
      pre_r   <= {PW{1'b0}};
      tick_r  <= 1'b0;
      clr_r   <= 1'b0;
      hold_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      pre_r   <= pre_nx_s;
      tick_r  <= tick_nx_s;
      clr_r   <= clr_nx_s;
      hold_r  <= (state_nx_s == S_LAP);
    end
  end

  assign tick  = tick_r;
  assign clr   = clr_r;
  assign hold  = hold_r;
  assign state = state_r;

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Run/stop/lap sequencer for the tenth-second stopwatch datapath. Converts two raw push-buttons into a four-state control FSM and generates the datapath's 0.1 s count enable, counter clear and display hold. Sits between the board buttons and the digit counters/seven-segment decoders: the counters advance only on `tick` and clear on `clr`, and the display latch freezes while `hold` is high.

## Interface
- `CLK_FREQ_HZ`, 50000000, input clock frequency.
- `TICK_HZ`, 10, tick rate; DIV = CLK_FREQ_HZ/TICK_HZ, integer, ≥2.
- `DEBOUNCE_CYCLES`, 1000000, stable-level cycles required by the debouncer (20 ms at 50 MHz); ≥1.

- `clk`  in  1  system clock, all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_ss`  in  1  raw start/stop button, active-high, asynchronous to `clk`.
- `btn_lr`  in  1  raw lap/reset button, active-high, asynchronous to `clk`.
- `cnt_max`  in  1  datapath reports count = 99.9 (all digits 9).
- `tick`  out  1  one-cycle count enable to the digit counters.
- `clr`  out  1  one-cycle clear pulse to the digit counters.
- `hold`  out  1  display-freeze level (lap view).
- `state`  out  2  FSM state: 00 IDLE, 01 RUN, 10 LAP, 11 STOP.

## Operation
- Button path, per button: 2-flop synchronizer → debouncer (see Configuration) → rising-edge detector. A press is a one-cycle pulse; a held button produces exactly one press. Releases are ignored.
- Prescaler: counter of width clog2(DIV). Counts 0..DIV-1 only in RUN or LAP. It holds its value in STOP, so a resume keeps the partial tenth. It is forced to 0 in IDLE.
- FSM transitions:
  - IDLE: ss → RUN; lr → IDLE with `clr` pulse.
  - RUN: ss → STOP; lr → LAP; overflow → STOP.
  - LAP: ss → STOP, hold released; lr → RUN; overflow → STOP.
  - STOP: ss → RUN; lr → IDLE with `clr` pulse.
- Outputs by state: `hold` = 1 only in LAP. `tick` can fire only in RUN or LAP.
- Tick: when the prescaler equals DIV-1 in RUN/LAP, it wraps to 0, and `tick` = 1 in the following cycle if `cnt_max` = 0.
- Overflow: if the prescaler equals DIV-1 and `cnt_max` = 1, no tick is issued, the prescaler goes to 0, the state goes to STOP, and `hold` goes to 0.
- Simultaneous events:
  - ss and lr pressed in the same cycle: ss wins; the lr press is dropped, not queued.
  - A press and an overflow in the same cycle: overflow wins, and the press is dropped.
- `tick`, `clr`, `hold` and `state` are all registered outputs.

## Timing
- Reset asserted (asynchronous): `state`=IDLE, `tick`=0, `clr`=0, `hold`=0, prescaler=0, synchronizers/debounced levels/edge registers=0, debounce counters=0. This applies immediately, including mid-RUN or mid-LAP.
- Button held through reset release is seen as a fresh press after normal latency.
- Press latency, with the raw level first sampled high at edge k:
  - debounce off: the FSM and outputs update at edge k+2;
  - debounce on: at edge k+2+DEBOUNCE_CYCLES.
- Tick period in RUN/LAP: exactly DIV cycles, including across a LAP entry/exit.
- Tick across STOP→RUN: the first tick arrives DIV minus the already-accumulated count cycles after resume.
- `clr` is high for exactly one cycle, coincident with `state` becoming IDLE.
- `tick` and `clr` are never high in the same cycle.

## Configuration
- `STOPWATCH_CTRL_DEBOUNCE_EN` defined: the debounced level follows the synchronized level only after it has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
- `STOPWATCH_CTRL_DEBOUNCE_EN` undefined: no debounce counters; the debounced level equals the synchronizer output, and `DEBOUNCE_CYCLES` is unused.

## Test plan
Parameters: CLK_FREQ_HZ=100, TICK_HZ=10 (DIV=10), DEBOUNCE_CYCLES=4, debounce enabled.
- Start and run: reset, then press ss for 10 cycles → `state`=01 at edge k+6; `tick` pulses every 10 cycles, `hold`=0, `clr` never asserted.
- Lap: in RUN, press lr → `state`=10 and `hold`=1 while tick spacing stays 10 cycles. Press lr again → `state`=01, `hold`=0.
- Stop, resume and clear:
  - press ss after 3 post-tick cycles → `state`=11, no ticks;
  - press ss → RUN, next tick 7 cycles later;
  - stop again and press lr → `state`=00 with a single 1-cycle `clr`.
- Bounce: toggle `btn_ss` high/low every 2 cycles for 20 cycles, then hold it high → exactly one press, 4 stable cycles after the last toggle. Repeat with debounce disabled → multiple presses.
- Overflow: drive `cnt_max`=1 in RUN → at the next prescaler wrap, `state`=11, `tick` stays 0, `hold`=0. Same result from LAP.
- Edge cases:
  - ss and lr pressed together in RUN → `state`=11, no LAP entry;
  - reset asserted mid-LAP → all outputs 0 and `state`=00 without waiting for a clock edge.
